// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Central sequencer for the 5-stage RISC-V datapath (IF, ID, EX, MEM, WB).
// It tracks the destination and type of the instruction held in EX, MEM and WB.
// From that it generates the per-stage register enables, bubbles and flushes,
// the PC increment/load, the EX operand forwarding selects, the data-memory
// request and a WB register-file write enable that fires once per instruction.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   id_valid .. id_is_store    decoded instruction currently in ID
//   branch_taken               branch in EX resolved taken
//   dmem_ready                 data memory completes its access this cycle
//   pc_inc, pc_load            sequential advance / branch-target load of the PC
//   if_id_en, if_id_flush      IF/ID write enable, IF/ID loads an invalid slot
//   id_ex_en, id_ex_bubble     ID/EX write enable, ID/EX loads a bubble
//   ex_mem_en, mem_wb_en       later pipeline register enables
//   fwd_a_sel, fwd_b_sel       EX operand source: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   dmem_req                   data memory access request
//   wb_reg_wr                  register file write enable for the WB instruction
//   mem_fault                  sticky flag: memory access exceeded MEM_TIMEOUT
//   stall_count                saturating count of cycles without PC progress
module pipeline_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [REG_ADDR_W-1:0]  id_rs1_addr,
    input  logic [REG_ADDR_W-1:0]  id_rs2_addr,
    input  logic                   id_uses_rs1,
    input  logic                   id_uses_rs2,
    input  logic [REG_ADDR_W-1:0]  id_rd_addr,
    input  logic                   id_reg_wr,
    input  logic                   id_is_load,
    input  logic                   id_is_store,
    input  logic                   branch_taken,
    input  logic                   dmem_ready,
    output logic                   pc_inc,
    output logic                   pc_load,
    output logic                   if_id_en,
    output logic                   if_id_flush,
    output logic                   id_ex_en,
    output logic                   id_ex_bubble,
    output logic                   ex_mem_en,
    output logic                   mem_wb_en,
    output logic [1:0]             fwd_a_sel,
    output logic [1:0]             fwd_b_sel,
    output logic                   dmem_req,
    output logic                   wb_reg_wr,
    output logic                   mem_fault,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_wr;
        logic                  load;
        logic                  store;
    } stage_t;

    state_t                state, state_nx;
    logic [WAIT_W-1:0]     wait_cnt, wait_nx;
    logic                  fault_set;

    stage_t                ex_rec, mem_rec;
    logic [REG_ADDR_W-1:0] ex_rs1, ex_rs2;
    logic                  wb_valid, wb_wr;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  wb_written;

    logic                  mem_access, load_use, br;

    // A stage "hits" register x when it holds a live write to x; x0 never counts.
    function automatic logic hit(input logic [REG_ADDR_W-1:0] x,
                                 input logic v, input logic w,
                                 input logic [REG_ADDR_W-1:0] rd);
        return v && w && (rd != '0) && (rd == x);
    endfunction

    assign mem_access = mem_rec.valid && (mem_rec.load || mem_rec.store);
    assign br         = branch_taken && ex_rec.valid;
    assign load_use   = id_valid && ex_rec.valid && ex_rec.load &&
                        ((id_uses_rs1 && hit(id_rs1_addr, ex_rec.valid, ex_rec.reg_wr, ex_rec.rd)) ||
                         (id_uses_rs2 && hit(id_rs2_addr, ex_rec.valid, ex_rec.reg_wr, ex_rec.rd)));

    // Sequencing decisions. A memory access that is not ready freezes the whole
    // pipe; otherwise a taken branch beats a load-use stall, which beats a
    // normal advance. A cycle in which a waiting access completes is handled
    // exactly like an ordinary RUN cycle.
    always_comb begin
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        if_id_en     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        dmem_req     = 1'b0;
        state_nx     = state;
        wait_nx      = wait_cnt;
        fault_set    = 1'b0;
        if (!rst) begin
            case (state)
                RUN, MEM_WAIT: begin
                    dmem_req = mem_access;
                    if (mem_access && !dmem_ready) begin
                        if (state == RUN) begin
                            state_nx = MEM_WAIT;
                            wait_nx  = WAIT_W'(1);
                        end else if (wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1)) begin
                            fault_set = 1'b1;
                            state_nx  = HALT;
                        end else begin
                            wait_nx = wait_cnt + 1'b1;
                        end
                    end else begin
                        state_nx  = RUN;
                        wait_nx   = '0;
                        ex_mem_en = 1'b1;
                        mem_wb_en = 1'b1;
                        id_ex_en  = 1'b1;
                        if (br) begin
                            pc_load      = 1'b1;
                            if_id_en     = 1'b1;
                            if_id_flush  = 1'b1;
                            id_ex_bubble = 1'b1;
                        end else if (load_use) begin
                            id_ex_bubble = 1'b1;
                        end else begin
                            pc_inc   = 1'b1;
                            if_id_en = 1'b1;
                        end
                    end
                end
                HALT: begin
                    state_nx = HALT;
                end
                default: begin
                    state_nx = RUN;
                    wait_nx  = '0;
                end
            endcase
        end
    end

    // Operand forwarding for EX. The younger MEM result wins over WB, but a load
    // in MEM has no data yet, so it only forwards once it reaches WB.
    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (!rst) begin
            if (hit(ex_rs1, mem_rec.valid, mem_rec.reg_wr, mem_rec.rd) && !mem_rec.load)
                fwd_a_sel = 2'b01;
            else if (hit(ex_rs1, wb_valid, wb_wr, wb_rd))
                fwd_a_sel = 2'b10;
            if (hit(ex_rs2, mem_rec.valid, mem_rec.reg_wr, mem_rec.rd) && !mem_rec.load)
                fwd_b_sel = 2'b01;
            else if (hit(ex_rs2, wb_valid, wb_wr, wb_rd))
                fwd_b_sel = 2'b10;
        end
    end

    // wb_written suppresses repeated writes while the WB slot is frozen.
    assign wb_reg_wr = !rst && wb_valid && wb_wr && (wb_rd != '0) && !wb_written;

    // Controller state, timeout flag and the stall performance counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_fault   <= 1'b0;
            stall_count <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
            if (fault_set)
                mem_fault <= 1'b1;
            if (!pc_inc && !pc_load && (stall_count != '1))
                stall_count <= stall_count + 1'b1;
        end
    end

    // Stage records follow their pipeline register enables; a bubble is an
    // all-zero record so it can neither hit nor be hit by forwarding.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_rec     <= '0;
            ex_rs1     <= '0;
            ex_rs2     <= '0;
            mem_rec    <= '0;
            wb_valid   <= 1'b0;
            wb_wr      <= 1'b0;
            wb_rd      <= '0;
            wb_written <= 1'b0;
        end else begin
            if (id_ex_en) begin
                if (id_ex_bubble) begin
                    ex_rec <= '0;
                    ex_rs1 <= '0;
                    ex_rs2 <= '0;
                end else begin
                    ex_rec <= '{valid: id_valid, rd: id_rd_addr, reg_wr: id_reg_wr,
                                load: id_is_load, store: id_is_store};
                    ex_rs1 <= id_rs1_addr;
                    ex_rs2 <= id_rs2_addr;
                end
            end
            if (ex_mem_en)
                mem_rec <= ex_rec;
            if (mem_wb_en) begin
                wb_valid   <= mem_rec.valid;
                wb_wr      <= mem_rec.reg_wr;
                wb_rd      <= mem_rec.rd;
                wb_written <= 1'b0;
            end else if (wb_reg_wr) begin
                wb_written <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
// Randomised bench for pipeline_ctrl. The bench plays the IF/ID register and
// the data memory. It keeps an instruction-level model of the pipe, in which
// each stage holds a whole instruction or nothing. Every cycle it pushes the
// outputs it expects into a queue, and an independent monitor pops and compares
// them on the falling edge.
module tb_pipeline_ctrl;

    localparam int AW  = 5;
    localparam int TMO = 15;
    localparam int SW  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_uses_rs1, id_uses_rs2, id_reg_wr, id_is_load, id_is_store;
    logic [AW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic          branch_taken, dmem_ready;
    logic          pc_inc, pc_load, if_id_en, if_id_flush, id_ex_en, id_ex_bubble;
    logic          ex_mem_en, mem_wb_en, dmem_req, wb_reg_wr, mem_fault;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic [SW-1:0] stall_count;

    always #5 clk = ~clk;

    pipeline_ctrl #(.REG_ADDR_W(AW), .MEM_TIMEOUT(TMO), .STALL_CNT_W(SW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd_addr(id_rd_addr),
        .id_reg_wr(id_reg_wr), .id_is_load(id_is_load), .id_is_store(id_is_store),
        .branch_taken(branch_taken), .dmem_ready(dmem_ready),
        .pc_inc(pc_inc), .pc_load(pc_load), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_bubble(id_ex_bubble), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .dmem_req(dmem_req), .wb_reg_wr(wb_reg_wr), .mem_fault(mem_fault),
        .stall_count(stall_count)
    );

    typedef struct packed {
        bit          valid;
        bit [AW-1:0] rd;
        bit [AW-1:0] rs1;
        bit [AW-1:0] rs2;
        bit          reg_wr;
        bit          load;
        bit          store;
        bit          use1;
        bit          use2;
    } instr_t;

    typedef struct packed {
        bit          pc_inc;
        bit          pc_load;
        bit          if_id_en;
        bit          if_id_flush;
        bit          id_ex_en;
        bit          id_ex_bubble;
        bit          ex_mem_en;
        bit          mem_wb_en;
        bit          dmem_req;
        bit          wb_reg_wr;
        bit          mem_fault;
        bit [1:0]    fa;
        bit [1:0]    fb;
        bit [SW-1:0] stall;
    } exp_t;

    exp_t   exp_q[$];
    int     err_cnt = 0;
    int     chk_cnt = 0;

    // Instruction-level model: what sits in ID/EX/MEM/WB, plus run status.
    instr_t id_i, ex_i, mem_i, wb_i;
    bit     halted, fault, wb_seen;
    int     busy;
    int     stalls;

    function automatic instr_t nop();
        instr_t t;
        t = '0;
        return t;
    endfunction

    // Small register range so hazards and x0 producers turn up often.
    function automatic instr_t rand_instr();
        instr_t t;
        int     kind;
        t = '0;
        if ($urandom_range(0, 99) >= 90)
            return t;
        t.valid = 1'b1;
        t.rd    = AW'($urandom_range(0, 7));
        t.rs1   = AW'($urandom_range(0, 7));
        t.rs2   = AW'($urandom_range(0, 7));
        t.use1  = 1'b1;
        kind    = $urandom_range(0, 99);
        if (kind < 25) begin
            t.load   = 1'b1;
            t.reg_wr = 1'b1;
        end else if (kind < 40) begin
            t.store = 1'b1;
            t.use2  = 1'b1;
        end else begin
            t.reg_wr = ($urandom_range(0, 9) != 0);
            t.use2   = $urandom_range(0, 1);
        end
        return t;
    endfunction

    function automatic bit produces(input instr_t s, input bit [AW-1:0] x);
        return s.valid && s.reg_wr && (s.rd != 0) && (s.rd == x);
    endfunction

    function automatic bit [1:0] source_of(input bit [AW-1:0] x);
        if (produces(mem_i, x) && !mem_i.load)
            return 2'b01;
        if (produces(wb_i, x))
            return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        id_i    = nop();
        ex_i    = nop();
        mem_i   = nop();
        wb_i    = nop();
        halted  = 1'b0;
        fault   = 1'b0;
        wb_seen = 1'b0;
        busy    = 0;
        stalls  = 0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        chk_cnt++;
        if (act !== req) begin
            err_cnt++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    // One cycle of stimulus. ready_mode 0 = random memory latency; N > 0 =
    // memory stays not-ready until the access has waited N cycles.
    task automatic applyStimulus(input bit do_rst, input int ready_mode);
        exp_t e;
        bit   mem_op, brk, lu;
        @(posedge clk);
        #1;
        rst          = do_rst;
        id_valid     = id_i.valid;
        id_rs1_addr  = id_i.rs1;
        id_rs2_addr  = id_i.rs2;
        id_uses_rs1  = id_i.use1;
        id_uses_rs2  = id_i.use2;
        id_rd_addr   = id_i.rd;
        id_reg_wr    = id_i.reg_wr;
        id_is_load   = id_i.load;
        id_is_store  = id_i.store;
        branch_taken = ($urandom_range(0, 9) == 0);
        if (ready_mode == 0)
            dmem_ready = ($urandom_range(0, 3) != 0);
        else
            dmem_ready = (busy >= ready_mode);

        e           = '0;
        e.mem_fault = fault;
        e.stall     = SW'(stalls);
        if (do_rst) begin
            exp_q.push_back(e);
            model_reset();
            return;
        end

        e.fa        = source_of(ex_i.rs1);
        e.fb        = source_of(ex_i.rs2);
        e.wb_reg_wr = wb_i.valid && wb_i.reg_wr && (wb_i.rd != 0) && !wb_seen;

        if (!halted) begin
            mem_op     = mem_i.valid && (mem_i.load || mem_i.store);
            e.dmem_req = mem_op;
            if (mem_op && !dmem_ready) begin
                busy++;
                if (busy >= TMO) begin
                    halted = 1'b1;
                    fault  = 1'b1;
                end
            end else begin
                busy = 0;
                brk  = branch_taken && ex_i.valid;
                lu   = id_i.valid && ex_i.valid && ex_i.load &&
                       ((id_i.use1 && produces(ex_i, id_i.rs1)) ||
                        (id_i.use2 && produces(ex_i, id_i.rs2)));
                e.ex_mem_en = 1'b1;
                e.mem_wb_en = 1'b1;
                e.id_ex_en  = 1'b1;
                wb_i  = mem_i;
                mem_i = ex_i;
                if (brk) begin
                    e.pc_load      = 1'b1;
                    e.if_id_en     = 1'b1;
                    e.if_id_flush  = 1'b1;
                    e.id_ex_bubble = 1'b1;
                    ex_i = nop();
                    id_i = nop();
                end else if (lu) begin
                    e.id_ex_bubble = 1'b1;
                    ex_i = nop();
                end else begin
                    e.pc_inc   = 1'b1;
                    e.if_id_en = 1'b1;
                    ex_i = id_i;
                    id_i = rand_instr();
                end
            end
        end

        if (!e.pc_inc && !e.pc_load && stalls < (1 << SW) - 1)
            stalls++;
        if (e.mem_wb_en)
            wb_seen = 1'b0;
        else if (e.wb_reg_wr)
            wb_seen = 1'b1;
        exp_q.push_back(e);
    endtask

    // Monitor: compares DUT outputs against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("pc_inc",       pc_inc,       e.pc_inc);
                checkOutput("pc_load",      pc_load,      e.pc_load);
                checkOutput("if_id_en",     if_id_en,     e.if_id_en);
                checkOutput("if_id_flush",  if_id_flush,  e.if_id_flush);
                checkOutput("id_ex_en",     id_ex_en,     e.id_ex_en);
                checkOutput("id_ex_bubble", id_ex_bubble, e.id_ex_bubble);
                checkOutput("ex_mem_en",    ex_mem_en,    e.ex_mem_en);
                checkOutput("mem_wb_en",    mem_wb_en,    e.mem_wb_en);
                checkOutput("dmem_req",     dmem_req,     e.dmem_req);
                checkOutput("wb_reg_wr",    wb_reg_wr,    e.wb_reg_wr);
                checkOutput("mem_fault",    mem_fault,    e.mem_fault);
                checkOutput("fwd_a_sel",    fwd_a_sel,    e.fa);
                checkOutput("fwd_b_sel",    fwd_b_sel,    e.fb);
                checkOutput("stall_count",  stall_count,  e.stall);
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        {id_valid, id_uses_rs1, id_uses_rs2, id_reg_wr, id_is_load, id_is_store} = '0;
        {id_rs1_addr, id_rs2_addr, id_rd_addr} = '0;
        branch_taken = 1'b0;
        dmem_ready   = 1'b0;
        model_reset();

        repeat (3) applyStimulus(1'b1, 0);

        // Mixed random traffic with occasional resets.
        for (int i = 0; i < 1500; i++)
            applyStimulus($urandom_range(0, 299) == 0, 0);

        // Longest wait that must still complete without a fault.
        for (int i = 0; i < 300; i++)
            applyStimulus(1'b0, TMO - 1);

        // Reset while the controller waits on memory.
        n = 0;
        while (busy != 3 && n < 400) begin
            applyStimulus(1'b0, TMO);
            n++;
        end
        applyStimulus(1'b1, 0);
        for (int i = 0; i < 50; i++)
            applyStimulus(1'b0, 0);

        // Memory never answers: must time out and halt.
        n = 0;
        while (mem_fault !== 1'b1 && n < 500) begin
            applyStimulus(1'b0, TMO);
            n++;
        end
        checkOutput("timeout_fault", mem_fault, 1);
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b0, 0);

        // Leave HALT through reset and run on.
        applyStimulus(1'b1, 0);
        for (int i = 0; i < 300; i++)
            applyStimulus(1'b0, 0);

        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        #1;
        if (exp_q.size() > 0) begin
            err_cnt++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
